pc_fetch_controller: RTL



---
 rtl/klp_pc_pkg.sv | 14 +
 rtl/pc_increment.sv | 11 +
 rtl/pc_fetch_controller.sv | 94 +++++++++
 3 files changed

// File: rtl/klp_pc_pkg.sv
// Shared definitions for the KLP32 program-counter / instruction-fetch logic.
package klp_pc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_HOLD   = 2'd2,
      ST_SQUASH = 2'd3
   } fetch_state_t;

   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam logic [1:0]  INST_ALIGN_MASK      = 2'b11;

endpackage

// File: rtl/pc_increment.sv
// Sequential next-PC adder; the sum wraps modulo 2^N.
module pc_increment #(
   parameter int N = 32
) (
   input  logic [N-1:0] pc_in,
   output logic [N-1:0] pc_out
);

   assign pc_out = pc_in + N'(4);

endmodule

// File: rtl/pc_fetch_controller.sv
// KLP32 PC sequencer: single-outstanding fetch handshake, decode back-pressure,
// and redirects that may squash a fetch already in flight.
module pc_fetch_controller
   import klp_pc_pkg::*;
#(
   parameter int           N            = 32,
   parameter logic [N-1:0] RESET_VECTOR = N'(RESET_VECTOR_DEFAULT)
) (
   input  logic         clk,
   input  logic         reset,
   output logic         imem_req,
   output logic [N-1:0] imem_addr,
   input  logic         imem_ack,
   input  logic [31:0]  imem_rdata,
   input  logic         redirect_valid,
   input  logic [N-1:0] redirect_target,
   input  logic         stall,
   output logic         inst_valid,
   output logic [31:0]  inst,
   output logic [N-1:0] inst_pc,
   output logic         misaligned
);

   fetch_state_t state;
   logic [N-1:0] pc;
   logic [N-1:0] pc_plus4;
   logic [N-1:0] squash_addr;
   logic         redirect_bad;
   logic         redirect_ok;

   assign redirect_bad = redirect_valid &&
                         ((redirect_target[1:0] & INST_ALIGN_MASK) != 2'b00);
   assign redirect_ok  = redirect_valid && !redirect_bad;

   pc_increment #(.N(N)) u_pc_increment (
      .pc_in  (pc),
      .pc_out (pc_plus4)
   );

   // While squashing, the stale request must keep its original address until acked.
   assign imem_req  = (state == ST_FETCH) || (state == ST_SQUASH);
   assign imem_addr = (state == ST_SQUASH) ? squash_addr : pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         pc          <= RESET_VECTOR;
         squash_addr <= RESET_VECTOR;
         inst_valid  <= 1'b0;
         inst        <= '0;
         inst_pc     <= '0;
         misaligned  <= 1'b0;
      end else begin
         misaligned <= redirect_bad;
         case (state)
            ST_IDLE: begin
               state <= ST_FETCH;
               if (redirect_ok) pc <= redirect_target;
            end
            ST_FETCH: begin
               if (redirect_ok) begin
                  pc <= redirect_target;
                  if (!imem_ack) begin
                     squash_addr <= pc;
                     state       <= ST_SQUASH;
                  end
               end else if (imem_ack) begin
                  inst       <= imem_rdata;
                  inst_pc    <= pc;
                  inst_valid <= 1'b1;
                  pc         <= pc_plus4;
                  state      <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (redirect_ok) begin
                  inst_valid <= 1'b0;
                  pc         <= redirect_target;
                  state      <= ST_FETCH;
               end else if (!stall) begin
                  inst_valid <= 1'b0;
                  state      <= ST_FETCH;
               end
            end
            ST_SQUASH: begin
               if (redirect_ok) pc <= redirect_target;
               if (imem_ack) state <= ST_FETCH;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
